// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and issue-FSM state type.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;
  localparam int IMM_I_LSB  = 20;
  localparam int IMM_I_MSB  = 31;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WRITEBACK = 2'd2
  } issue_state_e;

  // Sign-extended I-type immediate.
  function automatic logic [31:0] imm_i(input logic [31:0] word);
    return {{20{word[IMM_I_MSB]}}, word[IMM_I_MSB:IMM_I_LSB]};
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two operand read ports, one debug read port,
// one synchronous write port, x0 hard-wired to zero, write-first reads.
module register_file (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  debug_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] debug_data,
  input  logic        write_en,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // Next register contents; reading from here gives the write-first bypass.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_en && (write_addr != 5'd0)) begin
      regs_d[write_addr] = write_data;
    end
    regs_d[0] = 32'd0;
  end

  assign rs1_data   = regs_d[rs1_addr];
  assign rs2_data   = regs_d[rs2_addr];
  assign debug_data = regs_d[debug_addr];

  // Register storage, cleared by reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 32; i++) begin
      if (reset) begin
        regs_q[i] <= 32'd0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: rtl/operand_issue.sv
// Operand issue stage: decodes R/I-type ALU instructions, reads operands,
// drives a fixed-latency ALU and writes its result back.
module operand_issue
  import riscv_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        enable,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] register_data_1,
  output logic [31:0] register_data_2,
  input  logic [31:0] register_data_out,
  output logic        retire,
  output logic        illegal_instr,
  input  logic [4:0]  debug_addr,
  output logic [31:0] debug_data
);

  localparam logic [3:0] LATENCY = 4'(ALU_LATENCY);

  issue_state_e state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [6:0]  funct7_q, funct7_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        enable_q, enable_d;
  logic        retire_q, retire_d;
  logic        illegal_q, illegal_d;

  logic [6:0]  opcode;
  logic [2:0]  instr_funct3;
  logic        is_op, is_op_imm, is_shift;
  logic [31:0] rs1_data, rs2_data;
  logic        write_en;

  assign opcode       = instr[OPCODE_MSB:OPCODE_LSB];
  assign instr_funct3 = instr[FUNCT3_MSB:FUNCT3_LSB];
  assign is_op        = (opcode == OPCODE_OP);
  assign is_op_imm    = (opcode == OPCODE_OP_IMM);
  assign is_shift     = (instr_funct3 == 3'b001) || (instr_funct3 == 3'b101);
  assign write_en     = (state_q == WRITEBACK);

  register_file u_register_file (
    .clock      (clock),
    .reset      (reset),
    .rs1_addr   (instr[RS1_MSB:RS1_LSB]),
    .rs2_addr   (instr[RS2_MSB:RS2_LSB]),
    .debug_addr (debug_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .debug_data (debug_data),
    .write_en   (write_en),
    .write_addr (rd_q),
    .write_data (register_data_out)
  );

  // Next-state logic: accept in IDLE, count ALU latency in ISSUE, write back once.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    enable_d  = enable_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (is_op || is_op_imm) begin
            rd_d     = instr[RD_MSB:RD_LSB];
            funct3_d = instr_funct3;
            // Only shifts carry funct7 in an I-type word; ADDI must never look like SUB.
            funct7_d = (is_op || is_shift) ? instr[FUNCT7_MSB:FUNCT7_LSB] : 7'd0;
            op1_d    = rs1_data;
            op2_d    = is_op ? rs2_data : imm_i(instr);
            count_d  = LATENCY;
            enable_d = 1'b1;
            state_d  = ISSUE;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: begin
        retire_d = 1'b1;
        enable_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        enable_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= 4'd0;
      rd_q      <= 5'd0;
      funct3_q  <= 3'd0;
      funct7_q  <= 7'd0;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
      enable_q  <= 1'b0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_q      <= rd_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      enable_q  <= enable_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_ready     = (state_q == IDLE);
  assign enable          = enable_q;
  assign funct3          = funct3_q;
  assign funct7          = funct7_q;
  assign register_data_1 = op1_q;
  assign register_data_2 = op2_q;
  assign retire          = retire_q;
  assign illegal_instr   = illegal_q;

endmodule

// File: tb/tb_operand_issue.sv
// Self-checking bench for operand_issue with a one-cycle ALU emulation.
module tb_operand_issue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready;
  logic        enable;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] register_data_1;
  logic [31:0] register_data_2;
  logic [31:0] register_data_out;
  logic        retire;
  logic        illegal_instr;
  logic [4:0]  debug_addr = 5'd0;
  logic [31:0] debug_data;

  int compared = 0;
  int mismatched = 0;

  // Architectural register contents expected by the bench.
  logic [31:0] model [32];

  operand_issue #(.ALU_LATENCY(1)) dut (
    .clock             (clock),
    .reset             (reset),
    .instr_valid       (instr_valid),
    .instr             (instr),
    .instr_ready       (instr_ready),
    .enable            (enable),
    .funct3            (funct3),
    .funct7            (funct7),
    .register_data_1   (register_data_1),
    .register_data_2   (register_data_2),
    .register_data_out (register_data_out),
    .retire            (retire),
    .illegal_instr     (illegal_instr),
    .debug_addr        (debug_addr),
    .debug_data        (debug_data)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Emulated downstream ALU, answering from the DUT's issued operation.
  function automatic logic [31:0] aluModel(input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (f3)
      3'd0: r = f7[5] ? (a - b) : (a + b);
      3'd1: r = a << b[4:0];
      3'd2: r = {31'd0, $signed(a) < $signed(b)};
      3'd3: r = {31'd0, a < b};
      3'd4: r = a ^ b;
      3'd5: begin
        if (f7[5]) r = $signed(a) >>> b[4:0];
        else       r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // The ALU result is only meaningful while enabled; otherwise present junk.
  always_comb begin
    register_data_out = 32'hDEAD_BEEF;
    if (enable) register_data_out = aluModel(funct3, funct7, register_data_1, register_data_2);
  end

  // Architectural result of an RV32I ALU instruction given its source values.
  function automatic logic [31:0] refResult(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] b);
    logic        isR;
    logic [31:0] r;
    isR = (ins[6:0] == 7'b0110011);
    r = 32'd0;
    case (ins[14:12])
      3'd0: begin
        if (isR && ins[30]) r = a - b;
        else                r = a + b;
      end
      3'd1: r = a << b[4:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (ins[30]) r = $signed(a) >>> b[4:0];
        else         r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkDebug(input string tag, input logic [4:0] addr);
    debug_addr = addr;
    #1;
    checkOutput(tag, debug_data, model[addr]);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  // Present one instruction when ready and follow it through issue and writeback.
  task automatic applyStimulus(input logic [31:0] ins);
    logic [6:0]  opc;
    logic        isR, isI;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] a, b, res;
    logic [6:0]  f7;
    opc = ins[6:0];
    isR = (opc == 7'b0110011);
    isI = (opc == 7'b0010011);
    rd  = ins[11:7];
    rs1 = ins[19:15];
    rs2 = ins[24:20];
    f3  = ins[14:12];
    a   = model[rs1];
    b   = isR ? model[rs2] : {{20{ins[31]}}, ins[31:20]};
    f7  = (isR || f3 == 3'd1 || f3 == 3'd5) ? ins[31:25] : 7'd0;
    res = refResult(ins, a, b);

    @(negedge clock);
    checkOutput("ready_before", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr = ins;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr = $urandom;

    if (isR || isI) begin
      @(negedge clock);
      checkOutput("issue_enable", {31'd0, enable}, 32'd1);
      checkOutput("issue_ready", {31'd0, instr_ready}, 32'd0);
      checkOutput("issue_funct3", {29'd0, funct3}, {29'd0, f3});
      checkOutput("issue_funct7", {25'd0, funct7}, {25'd0, f7});
      checkOutput("issue_op1", register_data_1, a);
      checkOutput("issue_op2", register_data_2, b);
      checkOutput("issue_retire", {31'd0, retire}, 32'd0);
      @(negedge clock);
      checkOutput("wb_enable", {31'd0, enable}, 32'd1);
      checkOutput("wb_op2", register_data_2, b);
      debug_addr = rd;
      #1;
      checkOutput("wb_bypass", debug_data, (rd == 5'd0) ? 32'd0 : res);
      if (rd != 5'd0) model[rd] = res;
      @(negedge clock);
      checkOutput("retire_pulse", {31'd0, retire}, 32'd1);
      checkOutput("post_enable", {31'd0, enable}, 32'd0);
      checkOutput("post_ready", {31'd0, instr_ready}, 32'd1);
      checkOutput("post_op1_hold", register_data_1, a);
      checkDebug("rd_value", rd);
    end else begin
      @(negedge clock);
      checkOutput("illegal_pulse", {31'd0, illegal_instr}, 32'd1);
      checkOutput("illegal_enable", {31'd0, enable}, 32'd0);
      checkOutput("illegal_retire", {31'd0, retire}, 32'd0);
      checkOutput("illegal_ready", {31'd0, instr_ready}, 32'd1);
      @(negedge clock);
      checkOutput("illegal_once", {31'd0, illegal_instr}, 32'd0);
      checkOutput("illegal_no_retire", {31'd0, retire}, 32'd0);
    end
  endtask

  function automatic logic [31:0] randomInstr();
    logic [31:0] w;
    logic [2:0]  f3;
    logic [6:0]  opc;
    int          kind;
    kind = $urandom_range(0, 4);
    f3 = 3'($urandom_range(0, 7));
    w = $urandom;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[14:12] = f3;
    if (kind <= 1) begin
      w[6:0]   = 7'b0110011;
      w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    end else if (kind <= 3) begin
      w[6:0] = 7'b0010011;
      if (f3 == 3'd1 || f3 == 3'd5) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    end else begin
      opc = w[6:0];
      if (opc == 7'b0110011 || opc == 7'b0010011) opc = opc ^ 7'h10;
      w[6:0] = opc;
    end
    return w;
  endfunction

  // Directed sequence followed by randomized instructions.
  initial begin
    $display("[TB] start");
    clearModel();

    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("rst_enable", {31'd0, enable}, 32'd0);
    checkOutput("rst_retire", {31'd0, retire}, 32'd0);
    checkOutput("rst_illegal", {31'd0, illegal_instr}, 32'd0);
    checkOutput("rst_funct3", {29'd0, funct3}, 32'd0);
    checkOutput("rst_funct7", {25'd0, funct7}, 32'd0);
    checkOutput("rst_op1", register_data_1, 32'd0);
    checkOutput("rst_op2", register_data_2, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("ready_after_reset", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < 32; i++) checkDebug("reset_reg", 5'(i));

    applyStimulus(32'h0050_0093);
    applyStimulus(32'h0070_0113);
    applyStimulus(32'h4011_01B3);
    checkDebug("x1_is_5", 5'd1);
    checkOutput("x3_const", model[3], 32'd2);
    checkDebug("x3_is_2", 5'd3);

    applyStimulus(32'h0090_0013);
    checkDebug("x0_zero", 5'd0);

    applyStimulus(32'hFFF0_0213);
    applyStimulus(32'h4012_5293);
    checkOutput("x5_const", model[5], 32'hFFFF_FFFF);
    checkDebug("x5_value", 5'd5);

    applyStimulus(32'h0000_0000);
    for (int i = 0; i < 32; i++) checkDebug("after_illegal", 5'(i));

    for (int n = 0; n < 40; n++) begin
      applyStimulus(randomInstr());
    end

    // Reset while ADDI x6,x0,3 is in ISSUE abandons it.
    @(negedge clock);
    instr_valid = 1'b1;
    instr = 32'h0030_0313;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    @(negedge clock);
    checkOutput("abort_in_issue", {31'd0, enable}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort_enable", {31'd0, enable}, 32'd0);
    checkOutput("abort_retire", {31'd0, retire}, 32'd0);
    checkOutput("abort_idle", {31'd0, instr_ready}, 32'd1);
    reset = 1'b0;
    clearModel();
    @(negedge clock);
    checkOutput("abort_no_retire", {31'd0, retire}, 32'd0);
    checkDebug("abort_x6", 5'd6);
    checkOutput("abort_ready", {31'd0, instr_ready}, 32'd1);

    applyStimulus(32'h0050_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 Parameter ALU_LATENCY, default 1, number of cycles the downstream ALU needs from enable/operand change to valid register_data_out; legal range 1..15.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  upstream presents an instruction.
REQ-005 instr  input  32  RV32I instruction word.
REQ-006 instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 enable  output  1  ALU enable.
REQ-008 funct3  output  3  ALU operation select.
REQ-009 funct7  output  7  ALU operation modifier.
REQ-010 register_data_1  output  32  ALU operand A.
REQ-011 register_data_2  output  32  ALU operand B.
REQ-012 register_data_out  input  32  ALU result.
REQ-013 retire  output  1  one-cycle pulse when a result is written back.
REQ-014 illegal_instr  output  1  one-cycle pulse when an unsupported instruction is dropped.
REQ-015 debug_addr  input  5  register index for the bench read port.
REQ-016 debug_data  output  32  combinational read of register debug_addr.

Function
REQ-017 FSM states IDLE, ISSUE and WRITEBACK; instr_ready is 1 only in IDLE.
REQ-018 IDLE: on instr_valid with opcode 0110011 (R-type) or 0010011 (I-type), latch rd, funct3 and funct7, read operands, load latency counter with ALU_LATENCY, and go to ISSUE.
REQ-019 IDLE: on instr_valid with any other opcode, pulse illegal_instr next cycle, stay in IDLE, and leave all architectural state unchanged.
REQ-020 Operands: register_data_1 = x[rs1]; R-type register_data_2 = x[rs2]; I-type register_data_2 = sign-extended instr[31:20].
REQ-021 funct7: R-type passes instr[31:25]; I-type passes instr[31:25] only when funct3 is 001 or 101 (shifts), otherwise 0, so ADDI with imm[11:5]=0100000 is never issued as SUB.
REQ-022 ISSUE: enable=1 with operands, funct3 and funct7 registered and stable; counter decrements each cycle; when it reaches 0, go to WRITEBACK (ISSUE lasts exactly ALU_LATENCY cycles).
REQ-023 WRITEBACK: enable stays 1 with operands unchanged; sample register_data_out, write it to x[rd] unless rd=0, pulse retire, and return to IDLE.
REQ-024 Throughput: one instruction per ALU_LATENCY+2 cycles; an instruction accepted at edge N retires at edge N+ALU_LATENCY+1.
REQ-025 Outside ISSUE and WRITEBACK: enable=0; funct3, funct7 and operands hold their last values.
REQ-026 x0 always reads 0, and writes to x0 are discarded (retire still pulses).
REQ-027 A register read in the same cycle as a writeback to that register returns the new value (write-first bypass); this also applies to debug_data.
REQ-028 Back-to-back dependent instructions need no interlock, because the next instruction is not accepted until the previous write has completed.

Reset
REQ-029 While reset=1 at a clock edge: state=IDLE, all 32 registers=0, and enable, retire, illegal_instr, funct3, funct7, register_data_1 and register_data_2 = 0.
REQ-030 Reset in ISSUE or WRITEBACK abandons the instruction with no register write and no retire pulse.
REQ-031 instr_ready=1 in the first cycle after reset deasserts.

Structure
REQ-032 Shared package riscv_pkg holds OPCODE_OP=7'b0110011, OPCODE_OP_IMM=7'b0010011, the FSM state enum and instruction field-slice constants.
REQ-033 Sub-module register_file: 32x32, two combinational read ports plus a debug read port, one synchronous write port, x0 hard-wired to zero, write-first bypass.

Verification (bench drives register_data_out from a reference ALU model with ALU_LATENCY=1)
REQ-034 Reset, then debug reads of x0..x31 -> all 0, and instr_ready=1 one cycle after reset falls.
REQ-035 0x00500093 (ADDI x1,x0,5), then 0x00700113 (ADDI x2,x0,7), then 0x401101B3 (SUB x3,x2,x1) -> x1=5, x2=7, x3=2; the SUB issues with funct7=0x20; each retire occurs 2 cycles after acceptance.
REQ-036 0x00900013 (ADDI x0,x0,9) -> retire pulses and x0 reads 0.
REQ-037 0xFFF00213 (ADDI x4,x0,-1), then 0x40125293 (SRAI x5,x4,1) -> register_data_2=0xFFFFFFFF for the ADDI; SRAI issues with funct7=0x20, funct3=5; x5=0xFFFFFFFF.
REQ-038 0x00000000 with instr_valid=1 -> illegal_instr pulses once, no enable, no retire, registers unchanged.
REQ-039 Reset asserted during ISSUE of ADDI x6,x0,3 -> x6 remains 0, no retire, FSM in IDLE.
